// File: rtl/calc_sequencer.sv
// Keypad calculator sequencer: collects two decimal operands and an operator,
// launches the arithmetic unit, captures its result and supports chaining.
module calc_sequencer (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_key_valid,
    input  logic [3:0]  i_key_code,
    input  logic [39:0] i_result,
    input  logic        i_err,
    input  logic        i_sign,
    output logic [39:0] o_s1,
    output logic [39:0] o_s2,
    output logic        o_sign,
    output logic [1:0]  o_arith_func,
    output logic        o_en,
    output logic        o_clr,
    output logic [39:0] o_display,
    output logic        o_disp_neg,
    output logic        o_err,
    output logic        o_busy
);

    typedef enum logic [2:0] {
        ENTER_A, OP, ENTER_B, EXEC, WAIT, DONE, ERR
    } state_t;

    // Operands at or above this value already hold six digits.
    localparam logic [39:0] LIMIT = 40'd100000;

    state_t      state_q, state_d;
    logic [39:0] a_q, a_d;
    logic [39:0] b_q, b_d;
    logic        sign_q, sign_d;
    logic [1:0]  func_q, func_d;
    logic [39:0] res_q, res_d;
    logic        rsign_q, rsign_d;
    logic        clr_q, clr_d;
    logic        rel_q;

    logic        is_dig, is_op, is_eq, is_clr;
    logic [39:0] dig;
    logic [1:0]  op;

    assign is_dig = (i_key_code <= 4'd9);
    assign is_op  = (i_key_code >= 4'hA) && (i_key_code <= 4'hD);
    assign is_eq  = (i_key_code == 4'hE);
    assign is_clr = (i_key_code == 4'hF);
    assign dig    = {36'd0, i_key_code};
    assign op     = i_key_code[1:0] - 2'd2;

    // State and datapath registers; rel_q marks the first edge out of reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ENTER_A;
            a_q     <= '0;
            b_q     <= '0;
            sign_q  <= 1'b0;
            func_q  <= 2'b00;
            res_q   <= '0;
            rsign_q <= 1'b0;
            clr_q   <= 1'b0;
            rel_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sign_q  <= sign_d;
            func_q  <= func_d;
            res_q   <= res_d;
            rsign_q <= rsign_d;
            clr_q   <= clr_d;
            rel_q   <= 1'b0;
        end
    end

    // Next-state logic: clear wins over everything, busy states drop keys.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sign_d  = sign_q;
        func_d  = func_q;
        res_d   = res_q;
        rsign_d = rsign_q;
        clr_d   = rel_q;
        if (i_key_valid && is_clr) begin
            state_d = ENTER_A;
            a_d     = '0;
            b_d     = '0;
            sign_d  = 1'b0;
            func_d  = 2'b00;
            clr_d   = 1'b1;
        end else begin
            unique case (state_q)
                ENTER_A: begin
                    if (i_key_valid && is_dig) begin
                        if (a_q < LIMIT) a_d = a_q * 40'd10 + dig;
                    end else if (i_key_valid && is_op) begin
                        func_d  = op;
                        state_d = OP;
                    end
                end
                OP: begin
                    if (i_key_valid && is_op) begin
                        func_d = op;
                    end else if (i_key_valid && is_dig) begin
                        b_d     = dig;
                        state_d = ENTER_B;
                    end
                end
                ENTER_B: begin
                    if (i_key_valid && is_dig) begin
                        if (b_q < LIMIT) b_d = b_q * 40'd10 + dig;
                    end else if (i_key_valid && is_eq) begin
                        if (func_q == 2'b11 && b_q == '0) state_d = ERR;
                        else                              state_d = EXEC;
                    end
                end
                EXEC: state_d = WAIT;
                WAIT: begin
                    res_d   = i_result;
                    rsign_d = i_sign;
                    state_d = i_err ? ERR : DONE;
                end
                DONE: begin
                    if (i_key_valid && is_dig) begin
                        a_d     = dig;
                        b_d     = '0;
                        sign_d  = 1'b0;
                        state_d = ENTER_A;
                    end else if (i_key_valid && is_op) begin
                        a_d     = res_q;
                        sign_d  = rsign_q;
                        func_d  = op;
                        state_d = (rsign_q && op != 2'b01) ? ERR : OP;
                    end
                end
                ERR: ;
                default: state_d = ENTER_A;
            endcase
        end
    end

    // Display selection follows the calculation phase.
    always_comb begin
        o_display  = '0;
        o_disp_neg = 1'b0;
        unique case (state_q)
            ENTER_A, OP: begin
                o_display  = a_q;
                o_disp_neg = sign_q;
            end
            ENTER_B, EXEC, WAIT: o_display = b_q;
            DONE: begin
                o_display  = res_q;
                o_disp_neg = rsign_q;
            end
            ERR: ;
            default: ;
        endcase
    end

    assign o_s1         = a_q;
    assign o_s2         = b_q;
    assign o_sign       = sign_q;
    assign o_arith_func = func_q;
    assign o_en         = (state_q == EXEC);
    assign o_busy       = (state_q == EXEC) || (state_q == WAIT);
    assign o_err        = (state_q == ERR);
    assign o_clr        = clr_q;

endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 SHALL have ports: i_clk  input  1  single clock, all state changes on rising edge.
REQ-002 SHALL have ports: i_rst_n  input  1  synchronous, active-low reset.
REQ-003 SHALL have ports: i_key_valid  input  1  one-cycle keypad strobe.
REQ-004 SHALL have ports: i_key_code  input  4  4'h0-4'h9 digit, 4'hA add, 4'hB minus, 4'hC multiply, 4'hD divide, 4'hE equals, 4'hF clear.
REQ-005 SHALL have ports: i_result  input  40 / i_err  input  1 / i_sign  input  1  from arithmetic unit.
REQ-006 SHALL have ports: o_s1, o_s2  output  40  operands to arithmetic unit; o_sign  output  1  operand-1 negative flag.
REQ-007 SHALL have ports: o_arith_func  output  2  00 add, 01 minus, 10 multiply, 11 divide.
REQ-008 SHALL have ports: o_en  output  1  execute pulse; o_clr  output  1  arithmetic-unit reset pulse.
REQ-009 SHALL have ports: o_display  output  40; o_disp_neg  output  1; o_err  output  1; o_busy  output  1.

Function
REQ-010 SHALL implement states ENTER_A, OP, ENTER_B, EXEC, WAIT, DONE, ERR.
REQ-011 SHALL accept a key only on an edge with i_key_valid=1; keys other than clear arriving in EXEC or WAIT are dropped.
REQ-012 SHALL, on a digit in ENTER_A or ENTER_B, update the operand to operand*10+digit; digits that would make the operand exceed 6 digits are ignored.
REQ-013 SHALL, on an operator in ENTER_A, latch o_arith_func and go to OP; an operator in OP replaces the latched operator; an operator in ENTER_B is ignored.
REQ-014 SHALL, on a digit in OP, load operand B with that digit and go to ENTER_B.
REQ-015 SHALL ignore equals in ENTER_A and OP.
REQ-016 SHALL, on equals in ENTER_B with divide selected and B=0, go to ERR with o_err=1 and no o_en pulse.
REQ-017 SHALL, on any other equals in ENTER_B, go to EXEC: o_en=1 for exactly one cycle, then WAIT with o_en=0.
REQ-018 SHALL capture i_result, i_sign and i_err at the edge ending WAIT; the result is latched 2 edges after the accepting edge.
REQ-019 SHALL go to ERR with o_err=1 if captured i_err=1; otherwise go to DONE.
REQ-020 SHALL hold o_busy=1 in EXEC and WAIT only.
REQ-021 SHALL, on an operator in DONE, chain: A <= captured result, o_sign <= captured sign, go to OP.
REQ-022 SHALL, in the chaining case of REQ-021, go to ERR if the result is negative and the operator is not minus.
REQ-023 SHALL, on a digit in DONE, start a new calculation: A <= digit, o_sign=0, B=0, go to ENTER_A.
REQ-024 SHALL, in ERR, ignore all keys except clear.
REQ-025 SHALL, on clear in any state (including EXEC/WAIT), zero A, B, o_sign, o_err and the display, pulse o_clr for one cycle, and go to ENTER_A; clear has priority over every other event.
REQ-026 SHALL drive o_s1=A, o_s2=B and o_arith_func stable from the EXEC entry edge through the end of WAIT.
REQ-027 SHALL drive o_display=A in ENTER_A and OP, B in ENTER_B, and the captured result in DONE; o_disp_neg follows o_sign in ENTER_A/OP and the captured sign in DONE.
REQ-028 SHALL, in ERR, drive o_display=0 and o_disp_neg=0.

Reset
REQ-029 SHALL, on an edge with i_rst_n=0, enter ENTER_A and zero A, B, o_s1, o_s2, o_sign, o_arith_func, o_en, o_display, o_disp_neg, o_err and o_busy.
REQ-030 SHALL assert o_clr=1 for the single cycle following reset release.
REQ-031 SHALL abort any in-flight EXEC/WAIT on reset; reset overrides clear and keys on the same edge.

Verification
REQ-032 SHALL verify: keys 1,2 then add then 3,4 then equals -> o_s1=12, o_s2=34, o_arith_func=00, one o_en pulse; after 2 edges o_display=46 in DONE.
REQ-033 SHALL verify: 5, minus, 9, equals with unit sign=1 result=4 -> o_display=4, o_disp_neg=1; then minus, 1, equals -> o_sign=1 to the unit.
REQ-034 SHALL verify: 8, divide, 0, equals -> no o_en, o_err=1 in ERR; digit 7 is ignored; clear -> o_err=0, ENTER_A, o_clr pulse.
REQ-035 SHALL verify: seven digit-9 keys -> A=999999; the seventh digit is ignored.
REQ-036 SHALL verify: equals then a digit key arriving during WAIT -> the digit is dropped; clear arriving during WAIT -> ENTER_A and no capture.
REQ-037 SHALL verify: unit returns i_err=1 -> ERR; i_rst_n=0 mid-WAIT -> all outputs zero on the next edge.
